// File: rtl/wb_stage_if.sv
// Bus between the memory/write-back latch, the decode read ports and the
// processor output port of the write-back stage.
interface wb_stage_if #(
  parameter int DW = 8
);
  logic [1:0]    ra;
  logic [1:0]    rb;
  logic          RW;
  logic [1:0]    SP;
  logic          SW1;
  logic          SW2;
  logic          out_ld;
  logic [DW-1:0] DataOut;
  logic [1:0]    rd_addr1;
  logic [1:0]    rd_addr2;
  logic [DW-1:0] rd_data1;
  logic [DW-1:0] rd_data2;
  logic [DW-1:0] sp_value;
  // Output handshake: out_valid is high while out_port holds data the
  // consumer has not taken; the consumer takes it by raising out_ack for one
  // edge while out_valid is high. out_ack with out_valid low is ignored, and
  // an out_ld that lands on unconsumed, unacknowledged data sets out_ovf.
  logic [DW-1:0] out_port;
  logic          out_valid;
  logic          out_ack;
  logic          out_ovf;

  modport master (
    output ra, rb, RW, SP, SW1, SW2, out_ld, DataOut, rd_addr1, rd_addr2, out_ack,
    input  rd_data1, rd_data2, sp_value, out_port, out_valid, out_ovf
  );

  modport slave (
    input  ra, rb, RW, SP, SW1, SW2, out_ld, DataOut, rd_addr1, rd_addr2, out_ack,
    output rd_data1, rd_data2, sp_value, out_port, out_valid, out_ovf
  );
endinterface

// File: rtl/wb_stage.sv
// Write-back stage: register file commit, R3 stack pointer, output port.
// Define WB_BYPASS_EN for write-first (bypassed) decode read ports.
module wb_stage #(
  parameter int             DW       = 8,
  parameter logic [DW-1:0]  SP_RESET = 8'hFF
) (
  input  logic       clk,
  input  logic       reset,
  wb_stage_if.slave  bus
);

  logic [DW-1:0] regs_q [4];
  logic [DW-1:0] regs_d [4];
  logic [DW-1:0] out_port_q, out_port_d;
  logic          out_valid_q, out_valid_d;
  logic          out_ovf_q, out_ovf_d;

  logic [1:0]    dest;
  logic          sp_op;
  logic [DW-1:0] sp_next;

  always_comb begin
    dest    = bus.SW1 ? bus.rb : bus.ra;
    sp_op   = 1'b0;
    sp_next = regs_q[3];
    case (bus.SP)
      2'b01: begin sp_op = 1'b1; sp_next = regs_q[3] + 1'b1; end
      2'b10: begin sp_op = 1'b1; sp_next = regs_q[3] - 1'b1; end
      default: ;
    endcase
  end

  // The register write is applied after the SP update so it wins on R3.
  always_comb begin
    regs_d = regs_q;
    if (sp_op)
      regs_d[3] = sp_next;
    if (bus.RW)
      regs_d[dest] = bus.DataOut;
  end

  always_comb begin
    out_port_d  = out_port_q;
    out_valid_d = out_valid_q;
    out_ovf_d   = out_ovf_q;
    if (bus.out_ld) begin
      out_port_d  = bus.SW2 ? regs_q[bus.rb] : bus.DataOut;
      out_valid_d = 1'b1;
      if (out_valid_q && !bus.out_ack)
        out_ovf_d = 1'b1;
    end else if (bus.out_ack) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regs_q[0]   <= '0;
      regs_q[1]   <= '0;
      regs_q[2]   <= '0;
      regs_q[3]   <= SP_RESET;
      out_port_q  <= '0;
      out_valid_q <= 1'b0;
      out_ovf_q   <= 1'b0;
    end else begin
      regs_q      <= regs_d;
      out_port_q  <= out_port_d;
      out_valid_q <= out_valid_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

`ifdef WB_BYPASS_EN
  // Next-state view already encodes the RW-over-SP priority.
  assign bus.rd_data1 = regs_d[bus.rd_addr1];
  assign bus.rd_data2 = regs_d[bus.rd_addr2];
`else
  assign bus.rd_data1 = regs_q[bus.rd_addr1];
  assign bus.rd_data2 = regs_q[bus.rd_addr2];
`endif

  assign bus.sp_value  = regs_q[3];
  assign bus.out_port  = out_port_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_ovf   = out_ovf_q;

endmodule
